// File: rtl/posit_pkg.sv
// Shared types and constants for the binary32 -> posit<32,2> converter.
// Holds posit encodings, scale limits and the inter-stage payloads.
package posit_pkg;

    localparam logic [31:0] POSIT_NAR    = 32'h8000_0000;
    localparam logic [31:0] POSIT_MAXPOS = 32'h7FFF_FFFF;
    localparam logic [31:0] POSIT_MINPOS = 32'h0000_0001;

    localparam int FLOAT_BIAS = 127;

    localparam logic signed [8:0] SCALE_MAX = 9'sd120;
    localparam logic signed [8:0] SCALE_MIN = -9'sd120;

    // Unpacked binary32 after stage 1.
    typedef struct packed {
        logic              sign;
        logic signed [8:0] scale;
        logic [22:0]       frac;
        logic              zero;
        logic              special;
        logic              denorm;
    } s1_t;

    typedef enum logic [2:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_NAR,
        CLS_SAT_HI,
        CLS_SAT_LO
    } cls_e;

    // Positive posit body plus rounding bits after stage 2.
    typedef struct packed {
        cls_e        cls;
        logic        sign;
        logic [30:0] body;
        logic        guard;
        logic        sticky;
    } s2_t;

    function automatic logic [31:0] negate(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even of a 31-bit posit body, clamp, then apply sign.
// Ports: body/guard/sticky/sign in, 32-bit posit out (combinational).
module posit_round_rne
    import posit_pkg::*;
(
    input  logic [30:0] body,
    input  logic        guard,
    input  logic        sticky,
    input  logic        sign,
    output logic [31:0] posit
);

    logic        inc;
    logic [31:0] sum;
    logic [31:0] mag;

    assign inc = guard & (sticky | body[0]);
    assign sum = {1'b0, body} + {31'd0, inc};

    // Carry into bit 31 would alias NaR; a zero body would alias 0.
    always_comb begin
        mag = sum;
        if (sum[31]) begin
            mag = POSIT_MAXPOS;
        end else if (sum == 32'd0) begin
            mag = POSIT_MINPOS;
        end
    end

    assign posit = sign ? negate(mag) : mag;

endmodule

// File: rtl/float_to_posit_pipe.sv
// 3-stage valid/ready pipeline converting IEEE binary32 to posit<32,2>.
// Ports: clk, rst_n (async low), in_valid/in_ready/in_data,
//   out_valid/out_ready/out_data; with FLOAT_TO_POSIT_STATUS_EN also
//   out_status[2:0] = {nar, saturated, inexact} aligned with out_data.
module float_to_posit_pipe
    import posit_pkg::*;
#(
    parameter int N  = 32,
    parameter int ES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
`ifdef FLOAT_TO_POSIT_STATUS_EN
    ,
    output logic [2:0]   out_status
`endif
);

    logic v1, v2, v3;
    logic ld1, ld2, ld3;

    // A stage may load when empty or when its word moves on.
    assign ld3       = !v3 | out_ready;
    assign ld2       = !v2 | ld3;
    assign ld1       = !v1 | ld2;
    assign in_ready  = ld1;
    assign out_valid = v3;

    // ---------------- S1: unpack / classify
    s1_t        s1_d, s1_q;
    logic [7:0] exp_f;

    always_comb begin
        exp_f         = in_data[30:23];
        s1_d.sign     = in_data[31];
        s1_d.frac     = in_data[22:0];
        s1_d.scale    = $signed({1'b0, exp_f} - 9'(FLOAT_BIAS));
        s1_d.zero     = (exp_f == 8'd0) & (in_data[22:0] == 23'd0);
        s1_d.special  = (exp_f == 8'hFF);
        s1_d.denorm   = (exp_f == 8'd0) & (in_data[22:0] != 23'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            s1_q <= '0;
        end else begin
            if (ld1) v1 <= in_valid;
            if (ld1 & in_valid) s1_q <= s1_d;
        end
    end

    // ---------------- S2: regime build
    logic [6:0]    k;
    logic [ES-1:0] e;
    logic [5:0]    run;
    logic [5:0]    rl;
    logic [63:0]   regime;
    logic [63:0]   tail;
    logic [63:0]   str;
    logic          c_nar, c_zero, c_hi, c_lo, c_norm;
    s2_t           s2_d, s2_q;

    // Dropping the low ES bits of scale is the arithmetic shift.
    assign k = s1_q.scale[8:ES];
    assign e = s1_q.scale[ES-1:0];

    // run = number of identical regime bits before the terminator.
    assign run = k[6] ? (6'd0 - k[5:0]) : (k[5:0] + 6'd1);
    assign rl  = run + 6'd1;

    always_comb begin
        if (k[6]) regime = 64'h8000_0000_0000_0000 >> run;
        else      regime = ~({64{1'b1}} >> run);
        tail = {e, s1_q.frac, {(64-ES-23){1'b0}}} >> rl;
        str  = regime | tail;
    end

    assign c_nar  = s1_q.special;
    assign c_zero = s1_q.zero;
    assign c_lo   = !s1_q.special & (s1_q.denorm |
                    (!s1_q.zero & (s1_q.scale < SCALE_MIN)));
    assign c_hi   = !s1_q.special & (s1_q.scale >= SCALE_MAX);
    assign c_norm = !(c_nar | c_zero | c_lo | c_hi);

    always_comb begin
        s2_d.cls    = CLS_NORM;
        s2_d.sign   = s1_q.sign;
        s2_d.body   = str[63:33];
        s2_d.guard  = str[32];
        s2_d.sticky = |str[31:0];
        unique case (1'b1)
            c_nar:   s2_d.cls = CLS_NAR;
            c_zero:  s2_d.cls = CLS_ZERO;
            c_lo:    s2_d.cls = CLS_SAT_LO;
            c_hi:    s2_d.cls = CLS_SAT_HI;
            c_norm:  s2_d.cls = CLS_NORM;
            default: s2_d.cls = CLS_NORM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            s2_q <= '0;
        end else begin
            if (ld2) v2 <= v1;
            if (ld2 & v1) s2_q <= s2_d;
        end
    end

    // ---------------- S3: round / sign / specials
    logic [31:0] rnd;
    logic [31:0] res;

    posit_round_rne u_round (
        .body   (s2_q.body),
        .guard  (s2_q.guard),
        .sticky (s2_q.sticky),
        .sign   (s2_q.sign),
        .posit  (rnd)
    );

    always_comb begin
        res = rnd;
        unique case (s2_q.cls)
            CLS_ZERO:   res = 32'd0;
            CLS_NAR:    res = POSIT_NAR;
            CLS_SAT_HI: res = s2_q.sign ? negate(POSIT_MAXPOS)
                                        : POSIT_MAXPOS;
            CLS_SAT_LO: res = s2_q.sign ? negate(POSIT_MINPOS)
                                        : POSIT_MINPOS;
            default:    res = rnd;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3       <= 1'b0;
            out_data <= '0;
        end else begin
            if (ld3) v3 <= v2;
            if (ld3 & v2) out_data <= res;
        end
    end

`ifdef FLOAT_TO_POSIT_STATUS_EN
    logic st_nar, st_sat, st_inx;

    assign st_nar = (s2_q.cls == CLS_NAR);
    assign st_sat = (s2_q.cls == CLS_SAT_HI) | (s2_q.cls == CLS_SAT_LO);
    assign st_inx = st_sat |
                    ((s2_q.cls == CLS_NORM) & (s2_q.guard | s2_q.sticky));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_status <= 3'b000;
        end else if (ld3 & v2) begin
            out_status <= {st_nar, st_sat, st_inx};
        end
    end
`endif

endmodule

// File: tb/tb_float_to_posit_pipe.sv
// Self-checking bench for float_to_posit_pipe: directed vector table,
// backpressured random stream against a bit-serial model, async reset.
module tb_float_to_posit_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef FLOAT_TO_POSIT_STATUS_EN
    logic [2:0]  out_status;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    float_to_posit_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef FLOAT_TO_POSIT_STATUS_EN
        ,
        .out_status(out_status)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Independent reference: emit the posit bit string one bit at a time.
    function automatic logic [31:0] ref_p(input logic [31:0] f);
        logic [7:0]  ex;
        logic [22:0] fr;
        logic [63:0] str;
        logic [31:0] p;
        logic        g, st;
        int          s, k, e, pos;
        ex = f[30:23];
        fr = f[22:0];
        if (ex == 8'hFF) return 32'h8000_0000;
        if (ex == 8'd0 && fr == 23'd0) return 32'h0;
        s = int'(ex) - 127;
        if (ex == 8'd0 || s < -120) begin
            p = 32'h1;
        end else if (s >= 120) begin
            p = 32'h7FFF_FFFF;
        end else begin
            k = (s >= 0) ? s / 4 : -((3 - s) / 4);
            e = s - 4 * k;
            str = '0;
            pos = 63;
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) begin
                    str[pos] = 1'b1; pos--;
                end
                str[pos] = 1'b0; pos--;
            end else begin
                for (int i = 0; i < -k; i++) begin
                    str[pos] = 1'b0; pos--;
                end
                str[pos] = 1'b1; pos--;
            end
            str[pos] = e[1]; pos--;
            str[pos] = e[0]; pos--;
            for (int j = 22; j >= 0; j--) begin
                str[pos] = fr[j]; pos--;
            end
            p  = {1'b0, str[63:33]};
            g  = str[32];
            st = |str[31:0];
            if (g && (st || p[0])) p = p + 32'd1;
            if (p[31]) p = 32'h7FFF_FFFF;
            if (p == 32'd0) p = 32'd1;
        end
        if (f[31]) p = ~p + 32'd1;
        return p;
    endfunction

    typedef struct {
        logic [31:0] fin;
        logic [31:0] pexp;
        logic [2:0]  st;
    } vec_t;

    vec_t        tv[25];
    logic [31:0] rv[100];
    logic [31:0] q[$];
    logic [31:0] bexp[3];
    logic [31:0] bin[3];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, sent, recv, cyc;
        bit saw_full;

        // {input, expected posit, {nar, saturated, inexact}}
        tv[0]  = '{32'h3F80_0000, 32'h4000_0000, 3'b000};
        tv[1]  = '{32'h4000_0000, 32'h4800_0000, 3'b000};
        tv[2]  = '{32'h3F00_0000, 32'h3800_0000, 3'b000};
        tv[3]  = '{32'hBF80_0000, 32'hC000_0000, 3'b000};
        tv[4]  = '{32'h7F80_0000, 32'h8000_0000, 3'b100};
        tv[5]  = '{32'hFFC0_0000, 32'h8000_0000, 3'b100};
        tv[6]  = '{32'h0000_0000, 32'h0000_0000, 3'b000};
        tv[7]  = '{32'h8000_0000, 32'h0000_0000, 3'b000};
        tv[8]  = '{32'h7E96_7699, 32'h7FFF_FFFF, 3'b011};
        tv[9]  = '{32'h0000_0001, 32'h0000_0001, 3'b011};
        tv[10] = '{32'h8080_0000, 32'hFFFF_FFFF, 3'b011};
        // 1.0 + 1ulp still fits the 27 fraction bits at scale 0
        tv[11] = '{32'h3F80_0001, 32'h4000_0010, 3'b000};
        tv[12] = '{32'h7180_0001, 32'h7FFF_FFE0, 3'b001};
        tv[13] = '{32'h7190_0000, 32'h7FFF_FFE0, 3'b001};
        tv[14] = '{32'h71B0_0000, 32'h7FFF_FFE2, 3'b001};
        tv[15] = '{32'h7190_0001, 32'h7FFF_FFE1, 3'b001};
        tv[16] = '{32'h7B7F_FFFF, 32'h7FFF_FFFF, 3'b001};
        tv[17] = '{32'h7B80_0000, 32'h7FFF_FFFF, 3'b011};
        tv[18] = '{32'hFB80_0000, 32'h8000_0001, 3'b011};
        tv[19] = '{32'h0380_0000, 32'h0000_0001, 3'b000};
        tv[20] = '{32'h0300_0000, 32'h0000_0001, 3'b011};
        tv[21] = '{32'h0480_0000, 32'h0000_0002, 3'b001};
        tv[22] = '{32'hC000_0000, 32'hB800_0000, 3'b000};
        tv[23] = '{32'h3FC0_0000, 32'h4400_0000, 3'b000};
        tv[24] = '{32'h7F7F_FFFF, 32'h7FFF_FFFF, 3'b011};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_idle_valid", {31'd0, out_valid}, 32'd0);

        // Directed table: one word at a time, latency and value.
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = tv[i].fin;
            #1;
            chk($sformatf("tv%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 0;
            for (int n = 1; n <= 8; n++) begin
                if (out_valid) begin
                    lat = n;
                    break;
                end
                @(negedge clk);
            end
            chk($sformatf("tv%0d_latency", i), lat, 3);
            chk($sformatf("tv%0d_data", i), out_data, tv[i].pexp);
`ifdef FLOAT_TO_POSIT_STATUS_EN
            chk($sformatf("tv%0d_status", i), {29'd0, out_status},
                {29'd0, tv[i].st});
`endif
        end

        // Random stream with a backpressure window.
        for (int i = 0; i < 100; i++) begin
            rv[i] = {1'($urandom_range(0, 1)),
                     8'($urandom_range(1, 254)),
                     23'($urandom)};
        end
        sent = 0;
        recv = 0;
        cyc = 0;
        saw_full = 0;
        q.delete();
        while (recv < 100 && cyc < 1000) begin
            @(negedge clk);
            in_valid  = (sent < 100);
            in_data   = (sent < 100) ? rv[sent] : 32'd0;
            out_ready = !(cyc >= 10 && cyc <= 15);
            #1;
            chk($sformatf("rnd_in_ready_c%0d", cyc), {31'd0, in_ready},
                {31'd0, !(q.size() == 3 && !out_ready)});
            if (!in_ready) saw_full = 1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected_out", out_data, 32'hxxxx_xxxx);
                end else begin
                    chk($sformatf("rnd_data%0d", recv), out_data,
                        q.pop_front());
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_p(in_data));
                sent++;
            end
            cyc++;
        end
        chk("rnd_recv_count", recv, 100);
        chk("rnd_saw_full", {31'd0, saw_full}, 32'd1);
        chk("rnd_queue_empty", q.size(), 0);

        // Asynchronous reset in the middle of a burst.
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'h4040_0000 + 32'(i);
        end
        @(negedge clk);
        #1;
        chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_data", out_data, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        bin[0] = 32'h3F80_0000; bexp[0] = 32'h4000_0000;
        bin[1] = 32'h4000_0000; bexp[1] = 32'h4800_0000;
        bin[2] = 32'hBF80_0000; bexp[2] = 32'hC000_0000;
        sent = 0;
        recv = 0;
        cyc = 0;
        while (recv < 3 && cyc < 20) begin
            if (cyc > 0) @(negedge clk);
            in_valid = (sent < 3);
            in_data  = (sent < 3) ? bin[sent] : 32'd0;
            #1;
            if (out_valid) begin
                if (recv < 3)
                    chk($sformatf("post_rst_out%0d", recv), out_data,
                        bexp[recv]);
                recv++;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        chk("post_rst_recv_count", recv, 3);
        in_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
